fifo_frame_serializer: RTL and testbench

//  Parametrised successor of the phase-detector serial output stage. Pops words from a
//  non-FWFT (or FWFT) FIFO and shifts them out as framed serial words on NUM_LANES parallel

---
 rtl/fifo_frame_serializer.sv | 117 +++++++++++
 tb/tb_fifo_frame_serializer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_serializer.sv
// Pops words from a FIFO read port and shifts them out as framed serial words on
// NUM_LANES lanes that share one frame FSM and one gated serial clock.
module fifo_frame_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 1,
  parameter int RD_LATENCY = 2,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                            clk_shift_reg,
  input  logic                            rst,
  input  logic                            fifo_empty,
  output logic                            fifo_rd_en,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_LANES-1:0]            serial_out,
  output logic                            serial_valid,
  output logic                            serial_clk,
  output logic                            busy,
  output logic [15:0]                     frames_sent
);

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {IDLE, WAIT, START, DATA, PAR, STOP, GAP} state_t;

  state_t                               state;
  state_t                               state_nx;
  logic [CNT_W-1:0]                     cnt;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] shift;
  logic [NUM_LANES-1:0]                 par_bits;
  logic                                 capture;

  function automatic logic lane_parity(input logic [DATA_WIDTH-1:0] word);
    return (PARITY == 2) ? ~^word : ^word;
  endfunction

  assign fifo_rd_en = (state == IDLE) & ~fifo_empty & ~rst;
  assign busy       = (state != IDLE);
  assign serial_clk = ~clk_shift_reg & serial_valid;

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_rd_en) begin
          state_nx = (RD_LATENCY == 0) ? START : WAIT;
          capture  = (RD_LATENCY == 0);
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(RD_LATENCY - 1)) begin
          state_nx = START;
          capture  = 1'b1;
        end
      end
      START: state_nx = DATA;
      DATA: begin
        if (cnt == CNT_W'(DATA_WIDTH - 1))
          state_nx = (PARITY != 0) ? PAR : STOP;
      end
      PAR: state_nx = STOP;
      STOP: begin
        if (cnt == CNT_W'(STOP_BITS - 1))
          state_nx = (GAP_CYCLES != 0) ? GAP : IDLE;
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Lines derive only from registered state, so they change right after the edge.
  always_comb begin
    serial_out = '1;
    case (state)
      START: serial_out = '0;
      DATA: begin
        for (int k = 0; k < NUM_LANES; k++)
          serial_out[k] = (MSB_FIRST != 0) ? shift[k][DATA_WIDTH-1] : shift[k][0];
      end
      PAR:     serial_out = par_bits;
      default: serial_out = '1;
    endcase
  end

  always_ff @(posedge clk_shift_reg or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      serial_valid <= 1'b0;
      frames_sent  <= '0;
      shift        <= '0;
      par_bits     <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= (state_nx != state || state == IDLE) ? '0 : cnt + 1'b1;
      serial_valid <= (state_nx inside {START, DATA, PAR, STOP});
      if (state == STOP && state_nx != STOP)
        frames_sent <= frames_sent + 16'd1;
      for (int k = 0; k < NUM_LANES; k++) begin
        if (capture) begin
          shift[k]    <= fifo_data[k*DATA_WIDTH +: DATA_WIDTH];
          par_bits[k] <= lane_parity(fifo_data[k*DATA_WIDTH +: DATA_WIDTH]);
        end else if (state == DATA) begin
          shift[k] <= (MSB_FIRST != 0) ? {shift[k][DATA_WIDTH-2:0], 1'b0}
                                       : {1'b0, shift[k][DATA_WIDTH-1:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_frame_serializer.sv
// Bench for fifo_frame_serializer: three configurations fed by small FIFO models,
// directed cycle tables plus randomized traffic checked against a frame-level model.
module tb_fifo_frame_serializer;

  typedef struct {
    logic rd;
    logic out;
    logic vld;
    logic busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Expected lane bits at position idx of a frame of 8-bit lane words.
  function automatic logic [1:0] exp_bit(input logic [15:0] w, input int lanes, input int msb,
                                         input int par, input int idx);
    logic [1:0] r;
    logic [7:0] lw;
    r = 2'b11;
    for (int k = 0; k < lanes; k++) begin
      lw = w[k*8 +: 8];
      if (idx == 0) r[k] = 1'b0;
      else if (idx <= 8) r[k] = lw[(msb != 0) ? 8 - idx : idx - 1];
      else if (idx == 9 && par == 1) r[k] = ^lw;
      else if (idx == 9 && par == 2) r[k] = ~^lw;
    end
    if (lanes == 1) r[1] = 1'b0;
    return r;
  endfunction

  // A: RD_LATENCY 2, MSB first, even parity, 1 stop
  logic a_empty, a_rd, a_vld, a_sclk, a_busy;
  logic [7:0] a_data;
  logic [0:0] a_out;
  logic [15:0] a_fs;
  logic [7:0] a_mem [64];
  logic [5:0] a_wp = '0;
  logic [5:0] a_rp = '0;
  logic [7:0] a_s1 = '0;
  logic [7:0] a_s2 = '0;
  assign a_empty = (a_wp == a_rp);
  assign a_data  = a_s2;
  always @(posedge clk) begin
    if (a_rd) begin
      a_rp <= a_rp + 6'd1;
      a_s1 <= a_mem[a_rp];
    end
    a_s2 <= a_s1;
  end

  fifo_frame_serializer #(.DATA_WIDTH(8), .NUM_LANES(1), .RD_LATENCY(2), .MSB_FIRST(1),
                          .PARITY(1), .STOP_BITS(1), .GAP_CYCLES(0)) dut_a (
    .clk_shift_reg(clk), .rst(rst), .fifo_empty(a_empty), .fifo_rd_en(a_rd),
    .fifo_data(a_data), .serial_out(a_out), .serial_valid(a_vld), .serial_clk(a_sclk),
    .busy(a_busy), .frames_sent(a_fs));

  // B: FWFT, LSB first, odd parity, 1 stop
  logic b_empty, b_rd, b_vld, b_sclk, b_busy;
  logic [7:0] b_data;
  logic [0:0] b_out;
  logic [15:0] b_fs;
  logic [7:0] b_mem [64];
  logic [5:0] b_wp = '0;
  logic [5:0] b_rp = '0;
  assign b_empty = (b_wp == b_rp);
  assign b_data  = b_mem[b_rp];
  always @(posedge clk) if (b_rd) b_rp <= b_rp + 6'd1;

  fifo_frame_serializer #(.DATA_WIDTH(8), .NUM_LANES(1), .RD_LATENCY(0), .MSB_FIRST(0),
                          .PARITY(2), .STOP_BITS(1), .GAP_CYCLES(0)) dut_b (
    .clk_shift_reg(clk), .rst(rst), .fifo_empty(b_empty), .fifo_rd_en(b_rd),
    .fifo_data(b_data), .serial_out(b_out), .serial_valid(b_vld), .serial_clk(b_sclk),
    .busy(b_busy), .frames_sent(b_fs));

  // C: two lanes, RD_LATENCY 2, MSB first, no parity, 2 stops, 3 gap cycles
  logic c_empty, c_rd, c_vld, c_sclk, c_busy;
  logic [15:0] c_data;
  logic [1:0] c_out;
  logic [15:0] c_fs;
  logic [15:0] c_mem [64];
  logic [5:0] c_wp = '0;
  logic [5:0] c_rp = '0;
  logic [15:0] c_s1 = '0;
  logic [15:0] c_s2 = '0;
  assign c_empty = (c_wp == c_rp);
  assign c_data  = c_s2;
  always @(posedge clk) begin
    if (c_rd) begin
      c_rp <= c_rp + 6'd1;
      c_s1 <= c_mem[c_rp];
    end
    c_s2 <= c_s1;
  end

  fifo_frame_serializer #(.DATA_WIDTH(8), .NUM_LANES(2), .RD_LATENCY(2), .MSB_FIRST(1),
                          .PARITY(0), .STOP_BITS(2), .GAP_CYCLES(3)) dut_c (
    .clk_shift_reg(clk), .rst(rst), .fifo_empty(c_empty), .fifo_rd_en(c_rd),
    .fifo_data(c_data), .serial_out(c_out), .serial_valid(c_vld), .serial_clk(c_sclk),
    .busy(c_busy), .frames_sent(c_fs));

  task automatic push_a(input logic [7:0] w);
    a_mem[a_wp] = w;
    a_wp = a_wp + 6'd1;
  endtask
  task automatic push_b(input logic [7:0] w);
    b_mem[b_wp] = w;
    b_wp = b_wp + 6'd1;
  endtask
  task automatic push_c(input logic [15:0] w);
    c_mem[c_wp] = w;
    c_wp = c_wp + 6'd1;
  endtask

  // Frame-level reference: words in send order, each expands to an 11-bit frame.
  logic [15:0] mq_a [$];
  logic [15:0] mq_b [$];
  logic [15:0] mq_c [$];
  int mi_a = 0, mi_b = 0, mi_c = 0;
  int done_a = 0, done_b = 0, done_c = 0;
  bit mon_a = 0, mon_b = 0, mon_c = 0;

  always @(negedge clk) begin
    #1;
    if (mon_a) begin
      check("a_sclk_gate", 32'(a_sclk), 32'(a_vld));
      check("a_rd_only_idle", 32'(a_rd & a_busy), 0);
      if (a_vld) begin
        if (mq_a.size() == 0) check("a_extra_bit", 32'(a_vld), 0);
        else begin
          check("a_bit", 32'({1'b0, a_out}), 32'(exp_bit(mq_a[0], 1, 1, 1, mi_a)));
          mi_a++;
          if (mi_a == 11) begin mi_a = 0; void'(mq_a.pop_front()); done_a++; end
        end
      end
    end
    if (mon_b) begin
      check("b_sclk_gate", 32'(b_sclk), 32'(b_vld));
      check("b_rd_only_idle", 32'(b_rd & b_busy), 0);
      if (b_vld) begin
        if (mq_b.size() == 0) check("b_extra_bit", 32'(b_vld), 0);
        else begin
          check("b_bit", 32'({1'b0, b_out}), 32'(exp_bit(mq_b[0], 1, 0, 2, mi_b)));
          mi_b++;
          if (mi_b == 11) begin mi_b = 0; void'(mq_b.pop_front()); done_b++; end
        end
      end
    end
    if (mon_c) begin
      check("c_sclk_gate", 32'(c_sclk), 32'(c_vld));
      check("c_rd_only_idle", 32'(c_rd & c_busy), 0);
      if (c_vld) begin
        if (mq_c.size() == 0) check("c_extra_bit", 32'(c_vld), 0);
        else begin
          check("c_bit", 32'(c_out), 32'(exp_bit(mq_c[0], 2, 1, 0, mi_c)));
          mi_c++;
          if (mi_c == 11) begin mi_c = 0; void'(mq_c.pop_front()); done_c++; end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv2 [15];
    vec_t tv3 [13];
    logic [15:0] w4;
    logic [15:0] base_a, base_b, base_c;
    logic [31:0] rnd;
    logic [1:0] eo;

    // A, word 0xA5, second word queued behind it
    tv2[0]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tv2[1]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tv2[2]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tv2[3]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    tv2[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    tv2[5]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    tv2[6]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    tv2[7]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    tv2[8]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    tv2[9]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    tv2[10] = '{1'b0, 1'b0, 1'b1, 1'b1};
    tv2[11] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tv2[12] = '{1'b0, 1'b0, 1'b1, 1'b1};
    tv2[13] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tv2[14] = '{1'b1, 1'b1, 1'b0, 1'b0};
    // B, word 0x01, LSB first, odd parity 0
    tv3[0]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tv3[1]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    tv3[2]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 3; i <= 9; i++) tv3[i] = '{1'b0, 1'b0, 1'b1, 1'b1};
    tv3[10] = '{1'b0, 1'b0, 1'b1, 1'b1};
    tv3[11] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tv3[12] = '{1'b0, 1'b1, 1'b0, 1'b0};

    // Reset held with a non-empty FIFO
    rst = 1'b1;
    push_a(8'h5A);
    push_a(8'h81);
    repeat (2) @(negedge clk);
    #1;
    check("rst_rd_en", 32'(a_rd), 0);
    check("rst_serial_out", 32'(a_out), 1);
    check("rst_valid", 32'(a_vld), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_frames", 32'(a_fs), 0);
    check("rst_sclk", 32'(a_sclk), 0);
    check("rst_c_out", 32'(c_out), 3);

    // Release, then abort the frame of 0x5A mid-DATA
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_rd_en", 32'(a_rd), 1);
    for (int c = 1; c <= 6; c++) @(negedge clk);
    #1;
    check("mid_data_valid", 32'(a_vld), 1);
    rst = 1'b1;
    #1;
    check("abort_out", 32'(a_out), 1);
    check("abort_valid", 32'(a_vld), 0);
    check("abort_busy", 32'(a_busy), 0);
    check("abort_rd_en", 32'(a_rd), 0);
    @(negedge clk);
    rst = 1'b0;
    mq_a.push_back(16'h0081);
    mon_a = 1;
    #1;
    check("fresh_rd_en", 32'(a_rd), 1);
    check("abort_frames", 32'(a_fs), 0);
    for (int i = 0; i < 40 && done_a < 1; i++) @(negedge clk);
    #2;
    check("fresh_frame_done", done_a, 1);
    check("fresh_frames", 32'(a_fs), 1);
    mon_a = 0;

    // Cycle-exact frame timing on A
    @(negedge clk);
    base_a = a_fs;
    push_a(8'hA5);
    push_a(8'h3C);
    for (int c = 0; c < 15; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check($sformatf("t2_rd_c%0d", c), 32'(a_rd), 32'(tv2[c].rd));
      check($sformatf("t2_out_c%0d", c), 32'(a_out), 32'(tv2[c].out));
      check($sformatf("t2_vld_c%0d", c), 32'(a_vld), 32'(tv2[c].vld));
      check($sformatf("t2_busy_c%0d", c), 32'(a_busy), 32'(tv2[c].busy));
      check($sformatf("t2_sclk_c%0d", c), 32'(a_sclk), 32'(tv2[c].vld));
    end
    check("t2_frames", 32'(a_fs), 32'(16'(base_a + 16'd1)));
    repeat (16) @(negedge clk);
    #1;
    check("t2_frames2", 32'(a_fs), 32'(16'(base_a + 16'd2)));

    // FWFT, LSB first, odd parity on B
    @(negedge clk);
    push_b(8'h01);
    for (int c = 0; c < 13; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check($sformatf("t3_rd_c%0d", c), 32'(b_rd), 32'(tv3[c].rd));
      check($sformatf("t3_out_c%0d", c), 32'(b_out), 32'(tv3[c].out));
      check($sformatf("t3_vld_c%0d", c), 32'(b_vld), 32'(tv3[c].vld));
      check($sformatf("t3_busy_c%0d", c), 32'(b_busy), 32'(tv3[c].busy));
    end
    check("t3_frames", 32'(b_fs), 1);

    // Two lanes in lock-step, 2 stops, 3 gap cycles, back-to-back words on C
    @(negedge clk);
    w4 = 16'h3CF0;
    push_c(w4);
    push_c(16'h0FA5);
    for (int c = 0; c < 18; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c == 3) eo = 2'b00;
      else if (c >= 4 && c <= 11) eo = {w4[15 - (c - 4)], w4[7 - (c - 4)]};
      else eo = 2'b11;
      check($sformatf("t4_rd_c%0d", c), 32'(c_rd), 32'(c == 0 || c == 17));
      check($sformatf("t4_busy_c%0d", c), 32'(c_busy), 32'(!(c == 0 || c == 17)));
      check($sformatf("t4_vld_c%0d", c), 32'(c_vld), 32'(c >= 3 && c <= 13));
      check($sformatf("t4_out_c%0d", c), 32'(c_out), 32'(eo));
    end
    check("t4_frames", 32'(c_fs), 1);
    repeat (18) @(negedge clk);
    #1;
    check("t4_frames2", 32'(c_fs), 2);

    // Randomized traffic against the frame-level model
    @(negedge clk);
    base_a = a_fs; base_b = b_fs; base_c = c_fs;
    done_a = 0; done_b = 0; done_c = 0;
    mi_a = 0; mi_b = 0; mi_c = 0;
    mon_a = 1; mon_b = 1; mon_c = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0 && mq_a.size() < 12) begin
        rnd = $urandom;
        push_a(rnd[7:0]);
        mq_a.push_back({8'h00, rnd[7:0]});
      end
      if ($urandom_range(3) == 0 && mq_b.size() < 12) begin
        rnd = $urandom;
        push_b(rnd[7:0]);
        mq_b.push_back({8'h00, rnd[7:0]});
      end
      if ($urandom_range(4) == 0 && mq_c.size() < 12) begin
        rnd = $urandom;
        push_c(rnd[15:0]);
        mq_c.push_back(rnd[15:0]);
      end
    end
    for (int i = 0; i < 2000 && (mq_a.size() + mq_b.size() + mq_c.size()) != 0; i++)
      @(negedge clk);
    check("drain_pending", 32'(mq_a.size() + mq_b.size() + mq_c.size()), 0);
    repeat (2) @(negedge clk);
    #2;
    check("rand_frames_a", 32'(a_fs), 32'(16'(base_a + 16'(done_a))));
    check("rand_frames_b", 32'(b_fs), 32'(16'(base_b + 16'(done_b))));
    check("rand_frames_c", 32'(c_fs), 32'(16'(base_c + 16'(done_c))));
    check("rand_some_frames", 32'(done_a > 5 && done_b > 5 && done_c > 5), 1);
    mon_a = 0; mon_b = 0; mon_c = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
